// File: rtl/dmd_frame_mem_ctrl.sv
// Frame-history memory controller: for each incoming pixel word, fetch the co-located word of the
// previous frame over AXI4-Lite, write the current word back, and emit the {current, previous} pair.
module dmd_frame_mem_ctrl #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    PIX_CNT_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] BASE_A        = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_B        = ADDR_WIDTH'(32'h0010_0000),
  parameter int                    PINGPONG      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [PIX_CNT_WIDTH-1:0] cfg_pixels,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_cur,
  output logic [DATA_WIDTH-1:0]    out_prev,
  output logic                     out_last,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic                     frame_done,
  output logic                     err_len
);

  localparam int                       BYTES   = DATA_WIDTH / 8;
  localparam logic [PIX_CNT_WIDTH-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic                     alive_q;
  logic [PIX_CNT_WIDTH-1:0] idx_q;
  logic [PIX_CNT_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0]    cur_q;
  logic                     last_q;
  logic [DATA_WIDTH-1:0]    prev_q;
  logic                     first_q;
  logic                     buf_q;
  logic                     aw_done_q;
  logic                     w_done_q;

  logic [ADDR_WIDTH-1:0]    rd_base, wr_base, offs;
  logic [PIX_CNT_WIDTH:0]   idx_inc;
  logic                     len_bad;
  logic                     in_hs, cfg_hs, out_hs, wr_fin;

  function automatic logic [PIX_CNT_WIDTH-1:0] sat_inc(input logic [PIX_CNT_WIDTH-1:0] v);
    return (v == IDX_MAX) ? v : v + PIX_CNT_WIDTH'(1);
  endfunction

  function automatic logic [PIX_CNT_WIDTH-1:0] len_fix(input logic [PIX_CNT_WIDTH-1:0] v);
    return (v == '0) ? PIX_CNT_WIDTH'(1) : v;
  endfunction

  // buf_q=0: write A / read B; buf_q=1: write B / read A. Single-buffer mode always uses A.
  always_comb begin
    if (PINGPONG != 0) begin
      wr_base = buf_q ? BASE_B : BASE_A;
      rd_base = buf_q ? BASE_A : BASE_B;
    end else begin
      wr_base = BASE_A;
      rd_base = BASE_A;
    end
  end

  assign offs    = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(BYTES);
  assign idx_inc = {1'b0, idx_q} + (PIX_CNT_WIDTH + 1)'(1);
  // A saturated index overflows into the extra bit, so it never matches the configured length.
  assign len_bad = idx_inc != {1'b0, len_q};

  assign in_hs  = in_valid && in_ready;
  assign cfg_hs = cfg_valid && cfg_ready;
  assign out_hs = out_valid && out_ready;
  assign wr_fin = (aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready);

  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    cfg_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    out_valid     = 1'b0;
    out_cur       = '0;
    out_prev      = '0;
    out_last      = 1'b0;
    frame_done    = 1'b0;
    err_len       = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready  = alive_q;
        cfg_ready = alive_q && (idx_q == '0);
        if (alive_q && in_valid) state_d = first_q ? S_WR : S_RD_A;
      end
      S_RD_A: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = rd_base + offs;
        if (m_axi_arready) state_d = S_RD_D;
      end
      S_RD_D: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_d = S_WR;
      end
      S_WR: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_awaddr  = wr_base + offs;
        m_axi_wvalid  = !w_done_q;
        m_axi_wdata   = cur_q;
        if (wr_fin) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_cur   = cur_q;
        out_prev  = prev_q;
        out_last  = last_q;
        if (out_ready) begin
          state_d    = S_IDLE;
          frame_done = last_q;
          err_len    = last_q && len_bad;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // alive_q holds the input side off for the first cycle after reset so every output reads 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alive_q   <= 1'b0;
      idx_q     <= '0;
      len_q     <= PIX_CNT_WIDTH'(1);
      cur_q     <= '0;
      last_q    <= 1'b0;
      prev_q    <= '0;
      first_q   <= 1'b1;
      buf_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (cfg_hs) len_q <= len_fix(cfg_pixels);
      if (in_hs) begin
        cur_q  <= in_data;
        last_q <= in_last;
        if (first_q) prev_q <= '0;
      end
      if (m_axi_rready && m_axi_rvalid) prev_q <= m_axi_rdata;
      if (state_q == S_WR) begin
        if (wr_fin) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          if (m_axi_awready) aw_done_q <= 1'b1;
          if (m_axi_wready)  w_done_q  <= 1'b1;
        end
      end
      if (out_hs) begin
        if (last_q) begin
          idx_q   <= '0;
          first_q <= 1'b0;
          if (PINGPONG != 0) buf_q <= ~buf_q;
        end else begin
          idx_q <= sat_inc(idx_q);
        end
      end
    end
  end

endmodule
